singly_linked_list: RTL and testbench
=====================================

// Module: singly_linked_list
// PURPOSE
//  Hardware singly linked list of MAX_NODE nodes in a fixed register-file pool.
//  Serial op interface: read node by address, delete first node matching a value,
//  push back, push front. Exposes head/tail pointers, full/empty and fault status,
//  so a host can walk the list from head via next_node_addr.
// PARAMETERS
//  DATA_WIDTH  8  bit width of node payload
//  MAX_NODE    8  number of node slots; slot addresses 0..MAX_NODE-1
//  ADDR_WIDTH  $clog2(MAX_NODE+1) (localparam); NULL = all ones ({ADDR_WIDTH{1'b1}})
// PORTS
//  clk             in   1           single clock, rising edge
//  rst             in   1           asynchronous, active-low reset
//  data_in         in   DATA_WIDTH  value for push / delete-value
//  addr_in         in   ADDR_WIDTH  node address for read
//  op              in   2           0 Read, 1 Delete_value, 2 Push_back, 3 Push_front
//  op_start        in   1           request; sampled only while op_done=1
//  data_out        out  DATA_WIDTH  read data / deleted value (registered)
//  op_done         out  1           1 = idle/ready and previous op complete
//  next_node_addr  out  ADDR_WIDTH  next pointer of node just read (registered)
//  head            out  ADDR_WIDTH  address of first node, NULL when empty
//  tail            out  ADDR_WIDTH  address of last node, NULL when empty
//  full            out  1           node count == MAX_NODE (combinational from count)
//  empty           out  1           node count == 0 (combinational from count)
//  fault           out  1           last op failed; valid while op_done=1
// BEHAVIOUR
//  Storage: data[MAX_NODE], nxt[MAX_NODE], valid[MAX_NODE], count register.
//  Reset (rst=0, async): valid=0, count=0, head=tail=NULL, data_out=0,
//   next_node_addr=NULL, fault=0, op_done=1, FSM=IDLE.
//  FSM IDLE: op_done=1. op_start=1 at posedge -> latch op/data_in/addr_in,
//   op_done=0, fault=0, go EXEC. op_start held high = back-to-back ops.
//  EXEC (1 cycle) for push/read, then IDLE with op_done=1 (op_done low 1 cycle):
//   Push_back: slot = lowest index with valid=0; data=data_in, nxt=NULL,
//    valid=1; if empty head=tail=slot else nxt[tail]=slot, tail=slot; count++.
//   Push_front: same allocation; nxt[slot]=head; head=slot; if empty tail=slot.
//   Read: addr_in<MAX_NODE and valid -> data_out=data, next_node_addr=nxt.
//    Otherwise fault=1, data_out/next_node_addr unchanged.
//  Delete_value: EXEC sets cur=head, prev=NULL, goes FIND. FIND, one node/cycle:
//   data[cur]==data_in -> unlink: cur==head ? head=nxt[cur] : nxt[prev]=nxt[cur];
//   cur==tail -> tail=prev; valid[cur]=0; count--; data_out=data[cur]; IDLE.
//   No match: advance prev=cur, cur=nxt[cur]; cur==NULL -> fault=1, IDLE.
//   Only the first (head-most) match is removed.
//  Boundaries: push when full -> fault=1, no state change. Delete when empty ->
//   fault=1 after EXEC. Last node removed -> head=tail=NULL, empty=1.
//  Freed slots are reused (lowest free index first).
//  op/data_in/addr_in changes while busy are ignored (latched copy used).
//  Reset mid-operation aborts op, clears list, returns to IDLE immediately.
// TESTING
//  1 Reset, push_back 0x11,0x22,0x33 -> slots 0,1,2; head=0, tail=2, count 3.
//  2 Push_front 0x44,0x55,0x66 -> slots 3,4,5; head=5, tail=2;
//    walk from head gives data_out 66,55,44,11,22,33; last next_node_addr=NULL.
//  3 Delete_value 0x44 -> data_out=0x44, fault=0, walk 66,55,11,22,33;
//    next push_back 0x77 reuses slot 3, tail=3.
//  4 Delete_value 0x99 (absent) -> fault=1, list unchanged; delete head/tail
//    values update head/tail correctly.
//  5 Fill to 8 nodes -> full=1; 9th push -> fault=1, tail unchanged;
//    Read addr_in=NULL or freed slot -> fault=1.
//  6 Assert rst during a Delete FIND walk -> empty=1, head=tail=NULL, op_done=1.

Source files
------------

// File: rtl/singly_linked_list.sv
// Singly linked list over a fixed pool of MAX_NODE register-file slots.
// One op at a time: read by address, delete first value match, push back, push front.
module singly_linked_list #(
   parameter  int DATA_WIDTH = 8,
   parameter  int MAX_NODE   = 8,
   localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [1:0]            op,
   input  logic                  op_start,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  op_done,
   output logic [ADDR_WIDTH-1:0] next_node_addr,
   output logic [ADDR_WIDTH-1:0] head,
   output logic [ADDR_WIDTH-1:0] tail,
   output logic                  full,
   output logic                  empty,
   output logic                  fault
);

   localparam int                    IDX_W  = (MAX_NODE > 1) ? $clog2(MAX_NODE) : 1;
   localparam logic [ADDR_WIDTH-1:0] NULLA  = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] MAX_A  = ADDR_WIDTH'(MAX_NODE);
   localparam logic [1:0]            OP_READ  = 2'd0;
   localparam logic [1:0]            OP_DEL   = 2'd1;
   localparam logic [1:0]            OP_PBACK = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FIND} state_e;

   state_e                r_state;
   logic [DATA_WIDTH-1:0] r_data [MAX_NODE];
   logic [ADDR_WIDTH-1:0] r_nxt  [MAX_NODE];
   logic [MAX_NODE-1:0]   r_valid;
   logic [ADDR_WIDTH-1:0] r_count, r_head, r_tail, r_cur, r_prev, r_addr, r_nxt_out;
   logic [DATA_WIDTH-1:0] r_din, r_dout;
   logic [1:0]            r_op;
   logic                  r_done, r_fault;

   logic [ADDR_WIDTH-1:0] w_slot;
   logic [IDX_W-1:0]      w_slot_idx, w_cur_idx, w_prev_idx, w_tail_idx, w_addr_idx;
   logic                  w_full, w_empty, w_push, w_match, w_rd_ok;

   // Lowest free slot; NULL only when the pool is full.
   always_comb begin
      w_slot = NULLA;
      for (int i = MAX_NODE - 1; i >= 0; i--)
         if (!r_valid[i]) w_slot = ADDR_WIDTH'(i);
   end

   assign w_slot_idx = w_slot[IDX_W-1:0];
   assign w_cur_idx  = r_cur[IDX_W-1:0];
   assign w_prev_idx = r_prev[IDX_W-1:0];
   assign w_tail_idx = r_tail[IDX_W-1:0];
   assign w_addr_idx = r_addr[IDX_W-1:0];
   assign w_full     = (r_count == MAX_A);
   assign w_empty    = (r_count == '0);
   assign w_push     = (r_state == S_EXEC) && r_op[1] && !w_full;
   assign w_match    = (r_state == S_FIND) && (r_cur != NULLA) && (r_data[w_cur_idx] == r_din);
   assign w_rd_ok    = (r_addr < MAX_A) && r_valid[w_addr_idx];

   // Payload, link storage and the latched request need no reset: nothing reads them
   // before a valid bit or an accepted op qualifies them.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && op_start) begin
         r_op   <= op;
         r_din  <= data_in;
         r_addr <= addr_in;
      end
      if (w_push) begin
         r_data[w_slot_idx] <= r_din;
         r_nxt[w_slot_idx]  <= (r_op == OP_PBACK) ? NULLA : r_head;
         if (r_op == OP_PBACK && !w_empty) r_nxt[w_tail_idx] <= w_slot;
      end
      if (w_match && r_cur != r_head) r_nxt[w_prev_idx] <= r_nxt[w_cur_idx];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_valid   <= '0;
         r_count   <= '0;
         r_head    <= NULLA;
         r_tail    <= NULLA;
         r_cur     <= NULLA;
         r_prev    <= NULLA;
         r_dout    <= '0;
         r_nxt_out <= NULLA;
         r_fault   <= 1'b0;
         r_done    <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b1;
               if (op_start) begin
                  r_done  <= 1'b0;
                  r_fault <= 1'b0;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_op == OP_DEL) begin
                  r_cur   <= r_head;
                  r_prev  <= NULLA;
                  r_state <= S_FIND;
               end else begin
                  if (r_op == OP_READ) begin
                     if (w_rd_ok) begin
                        r_dout    <= r_data[w_addr_idx];
                        r_nxt_out <= r_nxt[w_addr_idx];
                     end else begin
                        r_fault <= 1'b1;
                     end
                  end else if (w_full) begin
                     r_fault <= 1'b1;
                  end else begin
                     r_valid[w_slot_idx] <= 1'b1;
                     r_count             <= r_count + ADDR_WIDTH'(1);
                     if (r_op == OP_PBACK) begin
                        r_tail <= w_slot;
                        if (w_empty) r_head <= w_slot;
                     end else begin
                        r_head <= w_slot;
                        if (w_empty) r_tail <= w_slot;
                     end
                  end
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            S_FIND: begin
               if (r_cur == NULLA) begin
                  r_fault <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else if (w_match) begin
                  if (r_cur == r_head) r_head <= r_nxt[w_cur_idx];
                  if (r_cur == r_tail) r_tail <= r_prev;
                  r_valid[w_cur_idx] <= 1'b0;
                  r_count            <= r_count - ADDR_WIDTH'(1);
                  r_dout             <= r_data[w_cur_idx];
                  r_done             <= 1'b1;
                  r_state            <= S_IDLE;
               end else begin
                  r_prev <= r_cur;
                  r_cur  <= r_nxt[w_cur_idx];
               end
            end
            default: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign data_out       = r_dout;
   assign next_node_addr = r_nxt_out;
   assign op_done        = r_done;
   assign head           = r_head;
   assign tail           = r_tail;
   assign fault          = r_fault;
   assign full           = w_full;
   assign empty          = w_empty;

endmodule

// File: tb/tb_singly_linked_list.sv
// Bench for singly_linked_list: directed scenarios plus random ops against a
// queue-based model of list order and slot allocation.
module tb_singly_linked_list;

   localparam int         MN    = 8;
   localparam logic [3:0] NULLA = 4'hF;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic [3:0] addr_in;
   logic [1:0] op;
   logic       op_start;
   logic [7:0] data_out;
   logic       op_done;
   logic [3:0] next_node_addr, head, tail;
   logic       full, empty, fault;

   singly_linked_list #(.DATA_WIDTH(8), .MAX_NODE(MN)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .addr_in(addr_in), .op(op),
      .op_start(op_start), .data_out(data_out), .op_done(op_done),
      .next_node_addr(next_node_addr), .head(head), .tail(tail),
      .full(full), .empty(empty), .fault(fault)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: slot pool plus a queue holding slot indices in list order.
   logic [7:0] m_data [MN];
   bit         m_valid[MN];
   int         m_list[$];
   logic [7:0] m_dout;
   logic [3:0] m_nxtout;
   bit         m_fault;
   logic [7:0] exp_q[$];

   function automatic logic [3:0] m_head();
      return (m_list.size() == 0) ? NULLA : 4'(m_list[0]);
   endfunction

   function automatic logic [3:0] m_tail();
      return (m_list.size() == 0) ? NULLA : 4'(m_list[m_list.size()-1]);
   endfunction

   task automatic m_clear();
      for (int i = 0; i < MN; i++) m_valid[i] = 1'b0;
      m_list.delete();
      m_dout   = 8'h00;
      m_nxtout = NULLA;
      m_fault  = 1'b0;
   endtask

   task automatic model_op(input int o, input logic [7:0] d, input int a);
      int k, slot;
      m_fault = 1'b0;
      case (o)
         0: begin
            if (a < MN && m_valid[a]) begin
               m_dout   = m_data[a];
               m_nxtout = NULLA;
               for (int i = 0; i < m_list.size(); i++)
                  if (m_list[i] == a && i + 1 < m_list.size()) m_nxtout = 4'(m_list[i+1]);
            end else m_fault = 1'b1;
         end
         1: begin
            k = -1;
            for (int i = 0; i < m_list.size(); i++)
               if (k < 0 && m_data[m_list[i]] == d) k = i;
            if (k >= 0) begin
               m_dout = d;
               m_valid[m_list[k]] = 1'b0;
               m_list.delete(k);
            end else m_fault = 1'b1;
         end
         default: begin
            if (m_list.size() == MN) m_fault = 1'b1;
            else begin
               slot = -1;
               for (int i = MN - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
               m_valid[slot] = 1'b1;
               m_data[slot]  = d;
               if (o == 2) m_list.push_back(slot);
               else        m_list.push_front(slot);
            end
         end
      endcase
   endtask

   task automatic compare_state(input string tag);
      chk_eq({tag, "/fault"}, fault, m_fault);
      chk_eq({tag, "/head"},  head,  m_head());
      chk_eq({tag, "/tail"},  tail,  m_tail());
      chk_eq({tag, "/full"},  full,  (m_list.size() == MN));
      chk_eq({tag, "/empty"}, empty, (m_list.size() == 0));
      chk_eq({tag, "/dout"},  data_out, m_dout);
      chk_eq({tag, "/nxt"},   next_node_addr, m_nxtout);
   endtask

   task automatic do_op(input logic [1:0] o, input logic [7:0] d, input logic [3:0] a);
      int g;
      @(negedge clk);
      g = 0;
      while (!op_done && g < 64) begin @(negedge clk); g++; end
      op = o; data_in = d; addr_in = a; op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      data_in = 8'($urandom); addr_in = 4'($urandom); op = 2'($urandom);
      g = 0;
      while (!op_done && g < 64) begin @(negedge clk); g++; end
      if (!op_done) chk_eq("op_timeout", op_done, 1'b1);
      model_op(int'(o), d, int'(a));
      compare_state($sformatf("op%0d", o));
   endtask

   task automatic walk(input string tag);
      logic [3:0] a;
      a = head;
      for (int i = 0; i < exp_q.size(); i++) begin
         do_op(2'd0, 8'h00, a);
         chk_eq($sformatf("%s_data%0d", tag, i), data_out, exp_q[i]);
         a = next_node_addr;
      end
      chk_eq({tag, "_end"}, a, NULLA);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; op_start = 1'b0; op = 2'd0; data_in = 8'h00; addr_in = 4'h0;
      m_clear();
      repeat (3) @(negedge clk);
      chk_eq("rst_done", op_done, 1'b1);
      compare_state("rst");
      rst = 1'b1;

      // 1: push_back fills slots 0..2
      do_op(2'd2, 8'h11, 4'h0);
      do_op(2'd2, 8'h22, 4'h0);
      do_op(2'd2, 8'h33, 4'h0);
      chk_eq("t1_head", head, 4'd0);
      chk_eq("t1_tail", tail, 4'd2);

      // 2: push_front takes slots 3..5
      do_op(2'd3, 8'h44, 4'h0);
      do_op(2'd3, 8'h55, 4'h0);
      do_op(2'd3, 8'h66, 4'h0);
      chk_eq("t2_head", head, 4'd5);
      chk_eq("t2_tail", tail, 4'd2);
      exp_q = '{8'h66, 8'h55, 8'h44, 8'h11, 8'h22, 8'h33};
      walk("t2_walk");

      // 3: delete from the middle, then slot reuse
      do_op(2'd1, 8'h44, 4'h0);
      chk_eq("t3_dout", data_out, 8'h44);
      chk_eq("t3_fault", fault, 1'b0);
      exp_q = '{8'h66, 8'h55, 8'h11, 8'h22, 8'h33};
      walk("t3_walk");
      do_op(2'd2, 8'h77, 4'h0);
      chk_eq("t3_tail", tail, 4'd3);

      // 4: absent value, head delete, tail delete
      do_op(2'd1, 8'h99, 4'h0);
      chk_eq("t4_absent", fault, 1'b1);
      do_op(2'd1, 8'h66, 4'h0);
      chk_eq("t4_head", head, 4'd4);
      do_op(2'd1, 8'h77, 4'h0);
      chk_eq("t4_tail", tail, 4'd2);

      // 5: fill, overflow, bad reads
      do_op(2'd2, 8'hA0, 4'h0);
      do_op(2'd2, 8'hA1, 4'h0);
      do_op(2'd2, 8'hA2, 4'h0);
      do_op(2'd2, 8'hA3, 4'h0);
      chk_eq("t5_full", full, 1'b1);
      do_op(2'd2, 8'hBB, 4'h0);
      chk_eq("t5_ovf_fault", fault, 1'b1);
      chk_eq("t5_ovf_tail", tail, 4'd7);
      do_op(2'd0, 8'h00, NULLA);
      chk_eq("t5_rd_null", fault, 1'b1);
      do_op(2'd0, 8'h00, 4'd8);
      chk_eq("t5_rd_oor", fault, 1'b1);
      do_op(2'd1, 8'h11, 4'h0);
      do_op(2'd0, 8'h00, 4'd0);
      chk_eq("t5_rd_freed", fault, 1'b1);

      // Random ops against the model
      for (int n = 0; n < 300; n++)
         do_op(2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

      // 6: reset in the middle of a delete walk
      while (m_list.size() < 3) do_op(2'd2, 8'($urandom_range(0, 15)), 4'h0);
      @(negedge clk);
      op = 2'd1; data_in = 8'hEE; op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_eq("t6_busy", op_done, 1'b0);
      #1 rst = 1'b0;
      #1;
      m_clear();
      chk_eq("t6_done", op_done, 1'b1);
      compare_state("t6");
      @(negedge clk);
      rst = 1'b1;
      do_op(2'd2, 8'h5A, 4'h0);
      chk_eq("t6_reuse_head", head, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
